param_sync_fifo: RTL and testbench

Parametrised single-clock FIFO, the next generation of the team's 8x8 synchronous FIFO. Adds configurable data width and depth, concurrent read/write in the same cycle, programmable almost-empty/almost-full thresholds, synchronous flush, and sticky overflow/underflow error flags. An optional first-word-fall-through (FWFT) read mode is selected at compile time. It sits between producer and consumer logic in the same clock domain as a rate-matching buffer.

---
 rtl/param_sync_fifo.sv | 102 ++++++++++
 tb/tb_param_sync_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised single-clock FIFO with threshold flags, flush and sticky errors
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module param_sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int AE_LEVEL   = 2,
   parameter int AF_LEVEL   = 14
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic                    rd_valid,
   output logic                    empty,
   output logic                    almost_empty,
   output logic                    half_full,
   output logic                    almost_full,
   output logic                    full,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] HALF_C  = CW'(DEPTH / 2);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count_q;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status depends only on the registered count, never on this cycle's requests.
   assign count        = count_q;
   assign empty        = (count_q == '0);
   assign full         = (count_q == DEPTH_C);
   assign half_full    = (count_q >= HALF_C);
   assign almost_empty = (count_q <= AE_C);
   assign almost_full  = (count_q >= AF_C);

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_acc && !rd_acc)
            count_q <= count_q + CNT_ONE;
         else if (rd_acc && !wr_acc)
            count_q <= count_q - CNT_ONE;
         if (wr_en && full)  overflow  <= 1'b1;
         if (rd_en && empty) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc && !flush) mem[wr_ptr] <= data_in;
   end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
   assign data_out = mem[rd_ptr];
   assign rd_valid = !empty;
`else
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         data_out <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) data_out <= mem[rd_ptr];
      end
   end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - randomized queue-model bench for param_sync_fifo
module tb_param_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AE    = 2;
   localparam int AF    = 14;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          flush;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          empty;
   logic          almost_empty;
   logic          half_full;
   logic          almost_full;
   logic          full;
   logic [4:0]    count;
   logic          overflow;
   logic          underflow;

   param_sync_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH     (DEPTH),
      .AE_LEVEL  (AE),
      .AF_LEVEL  (AF)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .flush        (flush),
      .wr_en        (wr_en),
      .data_in      (data_in),
      .rd_en        (rd_en),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .empty        (empty),
      .almost_empty (almost_empty),
      .half_full    (half_full),
      .almost_full  (almost_full),
      .full         (full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   string         phase  = "reset";

   logic [DW-1:0] q[$];
   logic          exp_ovf;
   logic          exp_unf;
   logic          exp_rv;
   logic [DW-1:0] exp_do;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      exp_rv  = 1'b0;
      exp_do  = '0;
   endfunction

   function automatic void model_update(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
      bit is_full;
      bit is_empty;
      if (f) begin
         model_reset();
         return;
      end
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      if (w && is_full)  exp_ovf = 1'b1;
      if (r && is_empty) exp_unf = 1'b1;
      exp_rv = r && !is_empty;
      if (r && !is_empty) exp_do = q.pop_front();
      if (w && !is_full)  q.push_back(d);
   endfunction

   task automatic check_all();
      int n;
      n = q.size();
      check({phase, ":count"},     32'(count),        32'(n));
      check({phase, ":empty"},     32'(empty),        32'(n == 0));
      check({phase, ":full"},      32'(full),         32'(n == DEPTH));
      check({phase, ":half_full"}, 32'(half_full),    32'(n >= DEPTH / 2));
      check({phase, ":alm_empty"}, 32'(almost_empty), 32'(n <= AE));
      check({phase, ":alm_full"},  32'(almost_full),  32'(n >= AF));
      check({phase, ":overflow"},  32'(overflow),     32'(exp_ovf));
      check({phase, ":underflow"}, 32'(underflow),    32'(exp_unf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
      check({phase, ":rd_valid"},  32'(rd_valid),     32'(n != 0));
      if (n != 0) check({phase, ":data_out"}, 32'(data_out), 32'(q[0]));
`else
      check({phase, ":rd_valid"},  32'(rd_valid),     32'(exp_rv));
      check({phase, ":data_out"},  32'(data_out),     32'(exp_do));
`endif
   endtask

   // Called at a falling edge; applies one cycle of inputs and checks after the next rising edge.
   task automatic step(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
      flush   = f;
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      @(posedge clk);
      model_update(f, w, r, d);
      @(negedge clk);
      check_all();
   endtask

   task automatic async_reset();
      flush = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(posedge clk);
      model_update(1'b0, 1'b0, 1'b0, '0);
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_all();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      flush   = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      data_in = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset_n = 1'b1;

      phase = "fill";
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(i));
      phase = "drain";
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b0, '0);

      phase = "full_wr_rd";
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
      step(1'b0, 1'b1, 1'b1, 8'hEE);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);

      phase = "empty_wr_rd";
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 8'hA5);
      step(1'b0, 1'b0, 1'b1, '0);
      step(1'b0, 1'b0, 1'b0, '0);

      phase = "wrap";
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, DW'($urandom_range(0, 255)));

      phase = "flush_prio";
      step(1'b1, 1'b0, 1'b0, '0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 16));
      step(1'b0, 1'b1, 1'b0, 8'h77);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, '0);
      step(1'b1, 1'b1, 1'b0, 8'h55);
      step(1'b0, 1'b0, 1'b0, '0);

      phase = "async_rst";
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom_range(0, 255)));
      async_reset();
      step(1'b0, 1'b1, 1'b0, 8'h3C);
      step(1'b0, 1'b0, 1'b1, '0);

      phase = "random";
      for (int blk = 0; blk < 5; blk++) begin
         int pw;
         int pr;
         pw = (blk % 2 == 0) ? 70 : 30;
         pr = 100 - pw;
         for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 99) < pw),
                 ($urandom_range(0, 99) < pr),
                 DW'($urandom_range(0, 255)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
